// File: rtl/alu_operand_loader_if.sv
// Operand-loader bus: raw switch/button inputs from the board side and the
// registered ALU operands, opcode, valid flag and state leaving the loader.
// The loader connects through the slave modport; the board side (or a bench)
// drives through the master modport.
interface alu_operand_loader_if #(
    parameter int M = 8
);
    logic [M-1:0] data_in;
    logic         enter;
    logic         clear;
    logic [M-1:0] A;
    logic [M-1:0] B;
    logic [1:0]   OpCode;
    logic         valid;
    logic [1:0]   state;

    modport slave (
        input  data_in,
        input  enter,
        input  clear,
        output A,
        output B,
        output OpCode,
        output valid,
        output state
    );

    modport master (
        output data_in,
        output enter,
        output clear,
        input  A,
        input  B,
        input  OpCode,
        input  valid,
        input  state
    );
endinterface

// File: rtl/alu_operand_loader.sv
// Sequential operand-entry front end for the M-bit ALU.
// Three button presses capture operand A, operand B and the 2-bit opcode
// from the switches; a fourth press drops the valid flag and restarts entry.
// The enter and clear buttons are synchronised with two flops each.
// Optional feature macro: ALU_LOADER_DEBOUNCE_EN adds a per-button debounce
// counter of DEBOUNCE_CYCLES stable cycles after the synchronisers.
module alu_operand_loader #(
    parameter int M               = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    alu_operand_loader_if.slave bus
);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_OP   = 2'b10,
        S_SHOW = 2'b11
    } state_t;

    // A zero-length debounce window would never accept a level change.
    if (DEBOUNCE_CYCLES < 1) begin : g_badDebounce
        $error("alu_operand_loader: DEBOUNCE_CYCLES must be at least 1");
    end

    logic [1:0]   r_enterSync;
    logic [1:0]   r_clearSync;
    logic         r_enterPrev;
    logic         w_enterLevel;
    logic         w_clearLevel;
    logic         w_press;
    state_t       r_state;
    logic [M-1:0] r_a;
    logic [M-1:0] r_b;
    logic [1:0]   r_opCode;
    logic         r_valid;

    // Bring both raw buttons into the clock domain with two flops each.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enterSync <= 2'b00;
            r_clearSync <= 2'b00;
        end else begin
            r_enterSync <= {r_enterSync[0], bus.enter};
            r_clearSync <= {r_clearSync[0], bus.clear};
        end
    end

`ifdef ALU_LOADER_DEBOUNCE_EN
    localparam int              CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] r_enterCnt;
    logic [CW-1:0] r_clearCnt;
    logic          r_enterDeb;
    logic          r_clearDeb;

    // Accept a new button level only after it has differed from the current
    // debounced level for DEBOUNCE_CYCLES consecutive cycles; any reversion
    // restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enterCnt <= '0;
            r_clearCnt <= '0;
            r_enterDeb <= 1'b0;
            r_clearDeb <= 1'b0;
        end else begin
            if (r_enterSync[1] != r_enterDeb) begin
                if (r_enterCnt == LAST) begin
                    r_enterDeb <= r_enterSync[1];
                    r_enterCnt <= '0;
                end else begin
                    r_enterCnt <= r_enterCnt + CW'(1);
                end
            end else begin
                r_enterCnt <= '0;
            end

            if (r_clearSync[1] != r_clearDeb) begin
                if (r_clearCnt == LAST) begin
                    r_clearDeb <= r_clearSync[1];
                    r_clearCnt <= '0;
                end else begin
                    r_clearCnt <= r_clearCnt + CW'(1);
                end
            end else begin
                r_clearCnt <= '0;
            end
        end
    end

    assign w_enterLevel = r_enterDeb;
    assign w_clearLevel = r_clearDeb;
`else
    assign w_enterLevel = r_enterSync[1];
    assign w_clearLevel = r_clearSync[1];
`endif

    // Remember the previous conditioned enter level so a held button gives a
    // single press pulse on its rising edge only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enterPrev <= 1'b0;
        end else begin
            r_enterPrev <= w_enterLevel;
        end
    end

    assign w_press = w_enterLevel & ~r_enterPrev;

    // Entry sequencer: clear wins over a coincident press; each press
    // captures the next field, and the press after a complete set retires it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_A;
            r_a      <= '0;
            r_b      <= '0;
            r_opCode <= 2'b00;
            r_valid  <= 1'b0;
        end else if (w_clearLevel) begin
            r_state  <= S_A;
            r_a      <= '0;
            r_b      <= '0;
            r_opCode <= 2'b00;
            r_valid  <= 1'b0;
        end else if (w_press) begin
            case (r_state)
                S_A: begin
                    r_a     <= bus.data_in;
                    r_state <= S_B;
                end
                S_B: begin
                    r_b     <= bus.data_in;
                    r_state <= S_OP;
                end
                S_OP: begin
                    r_opCode <= bus.data_in[1:0];
                    r_valid  <= 1'b1;
                    r_state  <= S_SHOW;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_A;
                end
            endcase
        end
    end

    assign bus.A      = r_a;
    assign bus.B      = r_b;
    assign bus.OpCode = r_opCode;
    assign bus.valid  = r_valid;
    assign bus.state  = r_state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with hand-computed expectations.
// Builds with or without ALU_LOADER_DEBOUNCE_EN; press/release hold times
// and the expected press latency follow the build.
module tb_alu_operand_loader;

    localparam int M  = 8;
    localparam int DB = 16;
`ifdef ALU_LOADER_DEBOUNCE_EN
    localparam int EXTRA = DB;
`else
    localparam int EXTRA = 0;
`endif
    localparam int SETTLE = EXTRA + 4;

    logic clk;
    logic reset;
    int   compareCount;
    int   mismatchCount;
    int   cycles;

    alu_operand_loader_if #(.M(M)) bus ();

    alu_operand_loader #(
        .M(M),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One button press: present the switches, hold enter, release, settle.
    task automatic applyStimulus(input logic [M-1:0] value, input int holdCycles);
        @(negedge clk);
        bus.data_in = value;
        bus.enter   = 1'b1;
        repeat (holdCycles) @(negedge clk);
        bus.enter = 1'b0;
        repeat (SETTLE) @(negedge clk);
    endtask

    task automatic checkAll(input string tag, input logic [M-1:0] a, input logic [M-1:0] b,
                            input logic [1:0] op, input logic v, input logic [1:0] st);
        checkOutput({tag, ".A"},      32'(bus.A),      32'(a));
        checkOutput({tag, ".B"},      32'(bus.B),      32'(b));
        checkOutput({tag, ".OpCode"}, 32'(bus.OpCode), 32'(op));
        checkOutput({tag, ".valid"},  32'(bus.valid),  32'(v));
        checkOutput({tag, ".state"},  32'(bus.state),  32'(st));
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        reset         = 1'b1;
        bus.data_in   = '0;
        bus.enter     = 1'b0;
        bus.clear     = 1'b0;
        repeat (3) @(negedge clk);
        checkAll("reset", 8'h00, 8'h00, 2'b00, 1'b0, 2'b00);
        reset = 1'b0;

        // Three clean presses build a complete ADD set.
        applyStimulus(8'h3C, SETTLE);
        checkAll("pressA", 8'h3C, 8'h00, 2'b00, 1'b0, 2'b01);
        applyStimulus(8'h05, SETTLE);
        checkAll("pressB", 8'h3C, 8'h05, 2'b00, 1'b0, 2'b10);
        applyStimulus(8'h01, SETTLE);
        checkAll("pressOp", 8'h3C, 8'h05, 2'b01, 1'b1, 2'b11);

        // Fourth press retires the set but keeps the operand values.
        applyStimulus(8'h77, SETTLE);
        checkAll("retire", 8'h3C, 8'h05, 2'b01, 1'b0, 2'b00);

        // Long hold gives exactly one capture.
        applyStimulus(8'hAA, 50);
        checkAll("holdA", 8'hAA, 8'h05, 2'b01, 1'b0, 2'b01);

        // Upper switch bits are ignored for the opcode.
        applyStimulus(8'h5B, SETTLE);
        applyStimulus(8'hFE, SETTLE);
        checkAll("opMask", 8'hAA, 8'h5B, 2'b10, 1'b1, 2'b11);
        applyStimulus(8'h00, SETTLE);
        applyStimulus(8'h11, SETTLE);
        checkAll("preClear", 8'h11, 8'h5B, 2'b10, 1'b0, 2'b01);

        // Clear and enter together in S_B: clear wins, press is lost.
        @(negedge clk);
        bus.data_in = 8'h99;
        bus.clear   = 1'b1;
        bus.enter   = 1'b1;
        repeat (SETTLE) @(negedge clk);
        checkAll("clearHeld", 8'h00, 8'h00, 2'b00, 1'b0, 2'b00);
        bus.clear = 1'b0;
        repeat (SETTLE) @(negedge clk);
        bus.enter = 1'b0;
        repeat (SETTLE) @(negedge clk);
        checkAll("clearDone", 8'h00, 8'h00, 2'b00, 1'b0, 2'b00);

        // Asynchronous reset in the middle of a cycle while in S_OP.
        applyStimulus(8'h22, SETTLE);
        applyStimulus(8'h33, SETTLE);
        checkOutput("toOp.state", 32'(bus.state), 32'h2);
        #2 reset = 1'b1;
        #1;
        checkAll("asyncReset", 8'h00, 8'h00, 2'b00, 1'b0, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(8'h44, SETTLE);
        checkAll("restart", 8'h44, 8'h00, 2'b00, 1'b0, 2'b01);

        // Press latency from a fresh S_A, counted in sampled cycles.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        bus.data_in = 8'h5A;
        bus.enter   = 1'b1;
        cycles      = 0;
        while (bus.state == 2'b00 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("latency", 32'(cycles), 32'(3 + EXTRA));
        checkOutput("latency.A", 32'(bus.A), 32'h5A);
        bus.enter = 1'b0;
        repeat (SETTLE) @(negedge clk);

`ifdef ALU_LOADER_DEBOUNCE_EN
        // A short glitch on enter must not be accepted.
        applyStimulus(8'h66, 10);
        checkAll("glitch", 8'h5A, 8'h00, 2'b00, 1'b0, 2'b01);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
